// File: rtl/muldiv_iterative_unit.sv
// Iterative RV32M/RV64M multiply/divide unit: radix-2 shift-add multiply and
// restoring divide on a shared {hi,lo} datapath, with sign fix-up after iteration.
module muldiv_iterative_unit #(
   parameter int XLEN = 32,
   localparam int CNT_W = $clog2(XLEN + 1)
) (
   input  logic            clk,
   input  logic            resetn,
   input  logic            valid,
   output logic            ready,
   input  logic            kill,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   output logic [XLEN-1:0] rd,
   output logic            done,
   output logic            busy
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [2:0]        f3_q, f3_d;
   logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d, opb_q, opb_d, rd_q, rd_d;
   logic              neg_q, neg_d, rneg_q, rneg_d, done_q, done_d;

   logic              accept_s, a_signed_s, b_signed_s, a_neg_s, b_neg_s;
   logic              div_zero_s, div_ovf_s, div_ge_s;
   logic [XLEN-1:0]   a_mag_s, b_mag_s, quo_s, rem_s, result_s;
   logic [XLEN:0]     mul_sum_s, div_shift_s;
   logic [2*XLEN-1:0] prod_s;

   function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v, input logic en);
      return en ? (~v + {{(XLEN-1){1'b0}}, 1'b1}) : v;
   endfunction

   function automatic logic [2*XLEN-1:0] neg2_if(input logic [2*XLEN-1:0] v, input logic en);
      return en ? (~v + {{(2*XLEN-1){1'b0}}, 1'b1}) : v;
   endfunction

   assign ready    = (state_q == S_IDLE) || (state_q == S_DONE);
   assign busy     = (state_q == S_CALC) || (state_q == S_FIX);
   assign accept_s = valid & ready;
   assign rd       = rd_q;
   assign done     = done_q;

   // Request decode: operand signedness, magnitudes and the divide corner cases
   always_comb begin
      a_signed_s = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                   (funct3 == 3'b100) || (funct3 == 3'b110);
      b_signed_s = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
      a_neg_s    = a_signed_s & rs1[XLEN-1];
      b_neg_s    = b_signed_s & rs2[XLEN-1];
      a_mag_s    = neg_if(rs1, a_neg_s);
      b_mag_s    = neg_if(rs2, b_neg_s);
      div_zero_s = funct3[2] & (rs2 == {XLEN{1'b0}});
      div_ovf_s  = funct3[2] & ~funct3[0] &
                   (rs1 == {1'b1, {(XLEN-1){1'b0}}}) & (rs2 == {XLEN{1'b1}});
   end

   // Per-iteration arithmetic and final sign fix-up / result select
   always_comb begin
      mul_sum_s   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : {(XLEN+1){1'b0}});
      div_shift_s = {hi_q, lo_q[XLEN-1]};
      div_ge_s    = div_shift_s >= {1'b0, opb_q};
      prod_s      = neg2_if({hi_q, lo_q}, neg_q);
      quo_s       = neg_if(lo_q, neg_q);
      rem_s       = neg_if(hi_q, rneg_q);
      case (f3_q)
         3'b000:                 result_s = prod_s[XLEN-1:0];
         3'b001, 3'b010, 3'b011: result_s = prod_s[2*XLEN-1:XLEN];
         3'b100, 3'b101:         result_s = quo_s;
         3'b110, 3'b111:         result_s = rem_s;
         default:                result_s = {XLEN{1'b0}};
      endcase
   end

   // Next-state logic for the FSM and shared datapath registers
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      f3_d    = f3_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      opb_d   = opb_q;
      neg_d   = neg_q;
      rneg_d  = rneg_q;
      rd_d    = rd_q;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (accept_s) begin
               f3_d   = funct3;
               neg_d  = a_neg_s ^ b_neg_s;
               rneg_d = a_neg_s;
               cnt_d  = CNT_W'(XLEN);
               hi_d   = {XLEN{1'b0}};
               // Divide iterates the dividend through lo; multiply iterates the multiplier.
               lo_d   = funct3[2] ? a_mag_s : b_mag_s;
               opb_d  = funct3[2] ? b_mag_s : a_mag_s;
               if (div_zero_s) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
                  rd_d    = funct3[1] ? rs1 : {XLEN{1'b1}};
               end else if (div_ovf_s) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
                  rd_d    = funct3[1] ? {XLEN{1'b0}} : rs1;
               end else begin
                  state_d = S_CALC;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_CALC: begin
            if (kill) begin
               state_d = S_IDLE;
            end else begin
               if (f3_q[2]) begin
                  hi_d = div_ge_s ? (div_shift_s[XLEN-1:0] - opb_q) : div_shift_s[XLEN-1:0];
                  lo_d = {lo_q[XLEN-2:0], div_ge_s};
               end else begin
                  hi_d = mul_sum_s[XLEN:1];
                  lo_d = {mul_sum_s[0], lo_q[XLEN-1:1]};
               end
               cnt_d   = cnt_q - CNT_W'(1);
               state_d = (cnt_q == CNT_W'(1)) ? S_FIX : S_CALC;
            end
         end
         S_FIX: begin
            if (kill) begin
               state_d = S_IDLE;
            end else begin
               rd_d    = result_s;
               done_d  = 1'b1;
               state_d = S_DONE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= S_IDLE;
         cnt_q   <= {CNT_W{1'b0}};
         f3_q    <= 3'b000;
         hi_q    <= {XLEN{1'b0}};
         lo_q    <= {XLEN{1'b0}};
         opb_q   <= {XLEN{1'b0}};
         neg_q   <= 1'b0;
         rneg_q  <= 1'b0;
         rd_q    <= {XLEN{1'b0}};
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         f3_q    <= f3_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         opb_q   <= opb_d;
         neg_q   <= neg_d;
         rneg_q  <= rneg_d;
         rd_q    <= rd_d;
         done_q  <= done_d;
      end
   end

endmodule
